// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keycode queue: key codes, set-2 prefix bytes,
// decoder state encoding and the scan-code lookup helpers.
package ps2_pkg;

  localparam logic [4:0] KEY_0     = 5'd0;
  localparam logic [4:0] KEY_1     = 5'd1;
  localparam logic [4:0] KEY_2     = 5'd2;
  localparam logic [4:0] KEY_3     = 5'd3;
  localparam logic [4:0] KEY_4     = 5'd4;
  localparam logic [4:0] KEY_5     = 5'd5;
  localparam logic [4:0] KEY_6     = 5'd6;
  localparam logic [4:0] KEY_7     = 5'd7;
  localparam logic [4:0] KEY_8     = 5'd8;
  localparam logic [4:0] KEY_9     = 5'd9;
  localparam logic [4:0] KEY_ENTER = 5'd10;
  localparam logic [4:0] KEY_BKSP  = 5'd11;
  localparam logic [4:0] KEY_ESC   = 5'd12;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } key_map_t;

  function automatic key_map_t map_main(input logic [7:0] b);
    key_map_t r;
    r = '0;
    r.hit = 1'b1;
    case (b)
      8'h45:   r.code = KEY_0;
      8'h16:   r.code = KEY_1;
      8'h1E:   r.code = KEY_2;
      8'h26:   r.code = KEY_3;
      8'h25:   r.code = KEY_4;
      8'h2E:   r.code = KEY_5;
      8'h36:   r.code = KEY_6;
      8'h3D:   r.code = KEY_7;
      8'h3E:   r.code = KEY_8;
      8'h46:   r.code = KEY_9;
      8'h5A:   r.code = KEY_ENTER;
      8'h66:   r.code = KEY_BKSP;
      8'h76:   r.code = KEY_ESC;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Numeric keypad digits arrive as plain (non-extended) makes in set 2.
  function automatic key_map_t map_keypad(input logic [7:0] b);
    key_map_t r;
    r = '0;
    r.hit = 1'b1;
    case (b)
      8'h70:   r.code = KEY_0;
      8'h69:   r.code = KEY_1;
      8'h72:   r.code = KEY_2;
      8'h7A:   r.code = KEY_3;
      8'h6B:   r.code = KEY_4;
      8'h73:   r.code = KEY_5;
      8'h74:   r.code = KEY_6;
      8'h6C:   r.code = KEY_7;
      8'h75:   r.code = KEY_8;
      8'h7D:   r.code = KEY_9;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Show-ahead synchronous FIFO for decoded key events; drop_o flags a push
// that could not be accepted because the queue stayed full.
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A pop frees the slot the same cycle, so a full queue can still accept a push.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FULL_COUNT) || do_pop);
    drop_o   = push_i && !do_push;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/ps2_keycode_queue.sv
// PS/2 set-2 make-code decoder feeding a key-event queue for CPU polling.
// Define PS2_KEYPAD_EN to also accept numeric keypad digits and keypad Enter.
module ps2_keycode_queue
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int PREFIX_TIMEOUT = 2_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    scan_byte,
  input  logic                          scan_valid,
  input  logic                          key_pop,
  input  logic                          ovf_clr,
  output logic [4:0]                    key_code,
  output logic                          key_valid,
  output logic [$clog2(FIFO_DEPTH):0]   key_count,
  output logic                          overflow
);

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PREFIX_TIMEOUT - 1);

  ps2_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          push_q, push_d;
  logic [4:0]    code_q, code_d;
  logic          ovf_q, ovf_d;
  logic          fifo_drop;
  key_map_t      dec;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dec     = '0;
    if (scan_valid) begin
      timer_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (scan_byte == PREFIX_BRK) begin
            state_d = ST_BRK;
          end else if (scan_byte == PREFIX_EXT) begin
            state_d = ST_EXT;
          end else begin
            dec = map_main(scan_byte);
`ifdef PS2_KEYPAD_EN
            if (!dec.hit) dec = map_keypad(scan_byte);
`endif
          end
        end
        ST_EXT: begin
          if (scan_byte == PREFIX_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
`ifdef PS2_KEYPAD_EN
            if (scan_byte == 8'h5A) dec = '{hit: 1'b1, code: KEY_ENTER};
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A prefix with no follow-up byte is abandoned so a lost byte cannot swallow the next make.
      if (timer_q == TIMER_LAST) begin
        state_d = ST_IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
    push_d = dec.hit;
    code_d = dec.code;
    ovf_d  = fifo_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      push_q  <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      push_q  <= push_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (5)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .data_i  (code_q),
    .pop_i   (key_pop),
    .data_o  (key_code),
    .valid_o (key_valid),
    .count_o (key_count),
    .drop_o  (fifo_drop)
  );

  assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_keycode_queue.sv
// Randomised and directed bench for ps2_keycode_queue against a byte-level
// reference model of the decoder and an ideal bounded queue.
module tb_ps2_keycode_queue;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_byte = 8'h00;
  logic       scan_valid = 1'b0;
  logic       key_pop = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [4:0] key_code;
  logic       key_valid;
  logic [3:0] key_count;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int mq[$];
  bit m_ovf, m_brk, m_ext;
  int m_last_edge = 0;
  logic [4:0] exp_code;
  logic [3:0] exp_cnt;
  logic       exp_vld, exp_ovf;

  int main_tbl[13] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46, 'h5A, 'h66, 'h76};
  int pad_tbl[10]  = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};
  int pool[30] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46, 'h5A, 'h66, 'h76,
                   'hE0, 'hF0, 'hF0, 'hE0, 'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C,
                   'h75, 'h7D, 'h1C, 'h00, 'hFF};

  ps2_keycode_queue #(
    .FIFO_DEPTH     (DEPTH),
    .PREFIX_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_byte  (scan_byte),
    .scan_valid (scan_valid),
    .key_pop    (key_pop),
    .ovf_clr    (ovf_clr),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_count  (key_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lookup_main(input int b);
    for (int i = 0; i < 13; i++) if (main_tbl[i] == b) return i;
`ifdef PS2_KEYPAD_EN
    for (int i = 0; i < 10; i++) if (pad_tbl[i] == b) return i;
`endif
    return -1;
  endfunction

  function automatic int lookup_ext(input int b);
`ifdef PS2_KEYPAD_EN
    if (b == 'h5A) return 10;
`endif
    return (b < 0) ? 0 : -1;
  endfunction

  // Returns the key code a byte completes, or -1; edge_idx is the sampling clock edge.
  function automatic int model_byte(input int b, input int edge_idx);
    if ((m_brk || m_ext) && (edge_idx - m_last_edge - 1 >= TMO)) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    m_last_edge = edge_idx;
    if (m_brk) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
      return -1;
    end
    if (b == 'hF0) begin
      m_brk = 1'b1;
      return -1;
    end
    if (m_ext) begin
      m_ext = 1'b0;
      return lookup_ext(b);
    end
    if (b == 'hE0) begin
      m_ext = 1'b1;
      return -1;
    end
    return lookup_main(b);
  endfunction

  function automatic void model_cycle(input int code, input bit pop, input bit clr);
    bit drop;
    drop = 1'b0;
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (code >= 0) begin
      if (mq.size() < DEPTH) mq.push_back(code);
      else drop = 1'b1;
    end
    m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
  endfunction

  function automatic void model_outputs();
    exp_vld  = (mq.size() > 0);
    exp_cnt  = 4'(mq.size());
    exp_code = (mq.size() > 0) ? 5'(mq[0]) : 5'd0;
    exp_ovf  = m_ovf;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit pop_with, input bit clr_with);
    int ev;
    @(negedge clk);
    scan_byte = b;
    scan_valid = 1'b1;
    ev = model_byte(int'(b), cyc + 1);
    @(negedge clk);
    scan_valid = 1'b0;
    key_pop = pop_with;
    ovf_clr = clr_with;
    @(negedge clk);
    key_pop = 1'b0;
    ovf_clr = 1'b0;
    model_cycle(ev, pop_with, clr_with);
  endtask

  task automatic pop_key();
    @(negedge clk);
    key_pop = 1'b1;
    @(negedge clk);
    key_pop = 1'b0;
    model_cycle(-1, 1'b1, 1'b0);
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    model_cycle(-1, 1'b0, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    for (int g = 0; g < 2 * DEPTH && mq.size() > 0; g++) pop_key();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    model_outputs();
    vectors++; if (key_valid !== exp_vld) begin miscompares++; $display("FAIL reset_valid: got %b expected %b", key_valid, exp_vld); end
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL reset_count: got %0d expected %0d", key_count, exp_cnt); end
    vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL reset_code: got %0d expected %0d", key_code, exp_code); end
    vectors++; if (overflow !== exp_ovf) begin miscompares++; $display("FAIL reset_ovf: got %b expected %b", overflow, exp_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_break();
    send_byte(8'h16, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h16, 1'b0, 1'b0);
    model_outputs();
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL break_count: got %0d expected %0d", key_count, exp_cnt); end
    vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL break_code: got %0d expected %0d", key_code, exp_code); end
  endtask

  task automatic test_extended();
    drain();
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    model_outputs();
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL ext_make_count: got %0d expected %0d", key_count, exp_cnt); end
    vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL ext_make_code: got %0d expected %0d", key_code, exp_code); end
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    model_outputs();
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL ext_break_count: got %0d expected %0d", key_count, exp_cnt); end
  endtask

  task automatic test_latency();
    int ev;
    drain();
    @(negedge clk);
    scan_byte = 8'h1E;
    scan_valid = 1'b1;
    ev = model_byte('h1E, cyc + 1);
    @(negedge clk);
    scan_valid = 1'b0;
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: got %b expected 0", key_valid); end
    @(negedge clk);
    model_cycle(ev, 1'b0, 1'b0);
    model_outputs();
    vectors++; if (key_valid !== exp_vld) begin miscompares++; $display("FAIL latency_valid: got %b expected %b", key_valid, exp_vld); end
    vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL latency_code: got %0d expected %0d", key_code, exp_code); end
  endtask

  task automatic test_overflow();
    drain();
    clear_ovf();
    for (int i = 0; i < 9; i++) send_byte(8'h45, 1'b0, 1'b0);
    model_outputs();
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL ovf_count: got %0d expected %0d", key_count, exp_cnt); end
    vectors++; if (overflow !== exp_ovf) begin miscompares++; $display("FAIL ovf_set: got %b expected %b", overflow, exp_ovf); end
    clear_ovf();
    model_outputs();
    vectors++; if (overflow !== exp_ovf) begin miscompares++; $display("FAIL ovf_clear: got %b expected %b", overflow, exp_ovf); end
    for (int i = 0; i < 8; i++) begin
      model_outputs();
      vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL ovf_pop_code[%0d]: got %0d expected %0d", i, key_code, exp_code); end
      pop_key();
    end
    pop_key();
    model_outputs();
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL underflow_count: got %0d expected %0d", key_count, exp_cnt); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] b;
    drain();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'(main_tbl[i]);
      send_byte(b, 1'b0, 1'b0);
    end
    send_byte(8'h46, 1'b1, 1'b0);
    model_outputs();
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL full_pp_count: got %0d expected %0d", key_count, exp_cnt); end
    vectors++; if (overflow !== exp_ovf) begin miscompares++; $display("FAIL full_pp_ovf: got %b expected %b", overflow, exp_ovf); end
    vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL full_pp_head: got %0d expected %0d", key_code, exp_code); end
    send_byte(8'h45, 1'b0, 1'b1);
    model_outputs();
    vectors++; if (overflow !== exp_ovf) begin miscompares++; $display("FAIL ovf_set_wins: got %b expected %b", overflow, exp_ovf); end
    clear_ovf();
  endtask

  task automatic test_empty_push_pop();
    drain();
    send_byte(8'h16, 1'b1, 1'b0);
    model_outputs();
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL empty_pp_count: got %0d expected %0d", key_count, exp_cnt); end
    vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL empty_pp_code: got %0d expected %0d", key_code, exp_code); end
  endtask

  task automatic test_timeout();
    drain();
    send_byte(8'hF0, 1'b0, 1'b0);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h26, 1'b0, 1'b0);
    model_outputs();
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL timeout_count: got %0d expected %0d", key_count, exp_cnt); end
    vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL timeout_code: got %0d expected %0d", key_code, exp_code); end
    drain();
    send_byte(8'hF0, 1'b0, 1'b0);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h26, 1'b0, 1'b0);
    model_outputs();
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL pre_timeout_count: got %0d expected %0d", key_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    drain();
    send_byte(8'h16, 1'b0, 1'b0);
    send_byte(8'h1E, 1'b0, 1'b0);
    send_byte(8'h26, 1'b0, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b0);
    pulse_reset();
    model_outputs();
    vectors++; if (key_valid !== exp_vld) begin miscompares++; $display("FAIL mid_rst_valid: got %b expected %b", key_valid, exp_vld); end
    vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL mid_rst_count: got %0d expected %0d", key_count, exp_cnt); end
    send_byte(8'h5A, 1'b0, 1'b0);
    model_outputs();
    vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL mid_rst_code: got %0d expected %0d", key_code, exp_code); end
  endtask

  task automatic test_random();
    int op;
    logic [7:0] b;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        b = 8'(pool[$urandom_range(0, 29)]);
        send_byte(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      end else if (op <= 7) begin
        pop_key();
      end else if (op == 8) begin
        clear_ovf();
      end else begin
        repeat ($urandom_range(1, 2 * TMO)) @(negedge clk);
      end
      model_outputs();
      vectors++; if (key_valid !== exp_vld) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, key_valid, exp_vld); end
      vectors++; if (key_count !== exp_cnt) begin miscompares++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, key_count, exp_cnt); end
      vectors++; if (key_code !== exp_code) begin miscompares++; $display("FAIL rnd_code[%0d]: got %0d expected %0d", i, key_code, exp_code); end
      vectors++; if (overflow !== exp_ovf) begin miscompares++; $display("FAIL rnd_ovf[%0d]: got %b expected %b", i, overflow, exp_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_break();
    test_extended();
    test_latency();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
